// File: rtl/ifmap_pkg.sv
// Shared helpers for the ifmap packer: lane/beat derivation and a ceiling log2.
// The FIFO entry layout {last, data} depends on MAC_NUM and ELEM_W, so the
// packed struct is declared inside axis_ifmap_packer where those widths exist.
package ifmap_pkg;

  // Ceiling log2, valid for constant expressions in parameter lists
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // One element per byte lane of the stream
  function automatic int unsigned lanes_of(input int unsigned tdata_width);
    return tdata_width / 8;
  endfunction

  // Beats needed to fill one MAC_NUM-element vector
  function automatic int unsigned bpv_of(input int unsigned mac_num, input int unsigned lanes);
    return mac_num / lanes;
  endfunction

endpackage

// File: rtl/axis_ifmap_packer_vec_fifo.sv
// vec_fifo: parametrised show-ahead FIFO with push, pop, synchronous flush and level.
// Pointers carry one extra bit so full and empty are distinguishable.
// The head output is forced to zero while the FIFO is empty.
module vec_fifo
  import ifmap_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty      = (wr_ptr == rd_ptr);
  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == LVL_W'(DEPTH));
  assign head_valid = !empty;
  assign head_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign do_pop     = pop && !empty && !flush;
  assign do_push    = push && (!full || do_pop) && !flush;

  // Pointer update; flush empties the FIFO and outranks push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axis_ifmap_packer.sv
// axis_ifmap_packer: AXI4-Stream slave that unpacks byte lanes into ELEM_W-bit
// activations, assembles MAC_NUM-element vectors and queues them in vec_fifo.
// TLAST closes a vector early (zero padded, tagged last); TSTRB zeroes lanes.
// Optional build macro AXIS_IFMAP_PACKER_STATS_EN adds vec_count/stall_count.
module axis_ifmap_packer
  import ifmap_pkg::*;
#(
  parameter int unsigned MAC_NUM              = 256,
  parameter int unsigned ELEM_W               = 5,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned DEPTH                = 4,
  localparam int unsigned LANES = lanes_of(C_S_AXIS_TDATA_WIDTH),
  localparam int unsigned BPV   = bpv_of(MAC_NUM, LANES),
  localparam int unsigned VEC_W = ELEM_W * MAC_NUM,
  localparam int unsigned LVL_W = clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  output logic                            S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [LANES-1:0]                S_AXIS_TSTRB,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TVALID,
  output logic [VEC_W-1:0]                vec_data,
  output logic                            vec_valid,
  input  logic                            vec_ready,
  output logic                            vec_last,
  output logic [LVL_W-1:0]                fifo_level
`ifdef AXIS_IFMAP_PACKER_STATS_EN
  ,
  output logic [31:0]                     vec_count,
  output logic [31:0]                     stall_count
`endif
);

  localparam int unsigned CNT_W = (BPV > 1) ? clog2(BPV) : 1;

  typedef struct packed {
    logic             last;
    logic [VEC_W-1:0] data;
  } fifo_entry_t;

  logic             tready_en;
  logic [CNT_W-1:0] beat_cnt;
  logic [VEC_W-1:0] asm_q;
  logic [VEC_W-1:0] asm_merged;
  logic             beat;
  logic             complete;
  logic             pop_req;
  logic             fifo_full;
  fifo_entry_t      push_entry;
  fifo_entry_t      head_entry;
  logic             unused_tdata;

  // Only the low ELEM_W bits of each lane carry data
  assign unused_tdata = ^S_AXIS_TDATA;

  // A pop in the same cycle frees a slot, so ready may stay high when full;
  // flush does not lower ready, it only drops the beat
  assign pop_req       = vec_ready && vec_valid;
  assign S_AXIS_TREADY = tready_en && (!fifo_full || pop_req);
  assign beat          = S_AXIS_TVALID && S_AXIS_TREADY && !flush;
  assign complete      = beat && ((beat_cnt == CNT_W'(BPV - 1)) || S_AXIS_TLAST);

  // Overlay the current beat's lanes onto the partial vector, zeroing strobed-off lanes
  always_comb begin
    asm_merged = asm_q;
    for (int b = 0; b < BPV; b++) begin
      if (beat_cnt == CNT_W'(b)) begin
        for (int k = 0; k < LANES; k++) begin
          asm_merged[(b*LANES+k)*ELEM_W +: ELEM_W] =
            S_AXIS_TSTRB[k] ? S_AXIS_TDATA[8*k +: ELEM_W] : '0;
        end
      end
    end
  end

  assign push_entry.last = S_AXIS_TLAST;
  assign push_entry.data = asm_merged;

  // Ready enable comes up one cycle after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tready_en <= 1'b0;
    else     tready_en <= 1'b1;
  end

  // Beat counter and assembly register; cleared after each push so padding is zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      asm_q    <= '0;
    end else if (flush || complete) begin
      beat_cnt <= '0;
      asm_q    <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 1'b1;
      asm_q    <= asm_merged;
    end
  end

  vec_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (complete),
    .push_data  (push_entry),
    .pop        (vec_ready),
    .head_data  (head_entry),
    .head_valid (vec_valid),
    .full       (fifo_full),
    .level      (fifo_level)
  );

  assign vec_data = head_entry.data;
  assign vec_last = head_entry.last;

`ifdef AXIS_IFMAP_PACKER_STATS_EN
  // Saturating push and stall counters, cleared by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_count   <= '0;
      stall_count <= '0;
    end else if (flush) begin
      vec_count   <= '0;
      stall_count <= '0;
    end else begin
      if (complete && (vec_count != 32'hFFFF_FFFF))
        vec_count <= vec_count + 32'd1;
      if (S_AXIS_TVALID && !S_AXIS_TREADY && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_ifmap_packer.sv
// Testbench for axis_ifmap_packer (MAC_NUM=8, ELEM_W=5, 32-bit stream, DEPTH=2).
// Stimulus is driven #1 after the rising edge; a monitor on the falling edge
// compares DUT outputs against a queue-based reference model of the stream rules.
module tb_axis_ifmap_packer;

  localparam int MAC_NUM = 8;
  localparam int ELEM_W  = 5;
  localparam int TDW     = 32;
  localparam int DEPTH   = 2;
  localparam int LANES   = TDW / 8;
  localparam int BPV     = MAC_NUM / LANES;
  localparam int VEC_W   = ELEM_W * MAC_NUM;
  localparam int LVL_W   = 2;

  typedef struct {
    logic [VEC_W-1:0] data;
    bit               last;
  } exp_vec_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             tready;
  logic [TDW-1:0]   tdata;
  logic [LANES-1:0] tstrb;
  logic             tlast;
  logic             tvalid;
  logic [VEC_W-1:0] vec_data;
  logic             vec_valid;
  logic             vec_ready;
  logic             vec_last;
  logic [LVL_W-1:0] fifo_level;
`ifdef AXIS_IFMAP_PACKER_STATS_EN
  logic [31:0]      vec_count;
  logic [31:0]      stall_count;
`endif

  int checks;
  int errors;

  // Reference model state
  exp_vec_t mq[$];
  int       part[MAC_NUM];
  int       mbeat;
  bit       ready_en_m;
  int       m_vec_count;
  int       m_stall_count;

  axis_ifmap_packer #(
    .MAC_NUM              (MAC_NUM),
    .ELEM_W               (ELEM_W),
    .C_S_AXIS_TDATA_WIDTH (TDW),
    .DEPTH                (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TVALID (tvalid),
    .vec_data      (vec_data),
    .vec_valid     (vec_valid),
    .vec_ready     (vec_ready),
    .vec_last      (vec_last),
    .fifo_level    (fifo_level)
`ifdef AXIS_IFMAP_PACKER_STATS_EN
    ,
    .vec_count     (vec_count),
    .stall_count   (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison with failure reporting
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Element list to packed vector: element i occupies bits [i*ELEM_W +: ELEM_W]
  function automatic logic [VEC_W-1:0] packElems(input int e[MAC_NUM]);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAC_NUM; i++) v = v | (VEC_W'(e[i] % (1 << ELEM_W)) << (i * ELEM_W));
    return v;
  endfunction

  function automatic void clearPart();
    for (int i = 0; i < MAC_NUM; i++) part[i] = 0;
    mbeat = 0;
  endfunction

  // Model of one accepted beat: lanes land at element mbeat*LANES+k
  function automatic void modelBeat(input logic [TDW-1:0] d, input logic [LANES-1:0] s, input bit l);
    exp_vec_t ev;
    for (int k = 0; k < LANES; k++)
      part[mbeat*LANES+k] = s[k] ? int'((d >> (8*k)) & ((1 << ELEM_W) - 1)) : 0;
    if (mbeat == BPV - 1 || l) begin
      ev.data = packElems(part);
      ev.last = l;
      mq.push_back(ev);
      m_vec_count++;
      clearPart();
    end else begin
      mbeat++;
    end
  endfunction

  // Monitor: compare on the falling edge, then advance the model to the next rising edge
  always @(negedge clk) begin
    bit exp_tready;
    if (rst) begin
      mq.delete();
      clearPart();
      ready_en_m    = 0;
      m_vec_count   = 0;
      m_stall_count = 0;
      checkOutput("rst_tready", 64'(tready), 64'd0);
      checkOutput("rst_valid", 64'(vec_valid), 64'd0);
      checkOutput("rst_last", 64'(vec_last), 64'd0);
      checkOutput("rst_level", 64'(fifo_level), 64'd0);
      checkOutput("rst_data", 64'(vec_data), 64'd0);
    end else begin
      exp_tready = ready_en_m && (mq.size() < DEPTH || (vec_ready && mq.size() > 0));
      checkOutput("tready", 64'(tready), 64'(exp_tready));
      checkOutput("vec_valid", 64'(vec_valid), 64'(mq.size() > 0));
      checkOutput("fifo_level", 64'(fifo_level), 64'(mq.size()));
      if (mq.size() > 0) begin
        checkOutput("vec_data", 64'(vec_data), 64'(mq[0].data));
        checkOutput("vec_last", 64'(vec_last), 64'(mq[0].last));
      end
`ifdef AXIS_IFMAP_PACKER_STATS_EN
      checkOutput("vec_count", 64'(vec_count), 64'(m_vec_count));
      checkOutput("stall_count", 64'(stall_count), 64'(m_stall_count));
`endif
      if (flush) begin
        mq.delete();
        clearPart();
        m_vec_count   = 0;
        m_stall_count = 0;
      end else begin
        if (tvalid && !exp_tready) m_stall_count++;
        if (vec_ready && mq.size() > 0) void'(mq.pop_front());
        if (tvalid && exp_tready) modelBeat(tdata, tstrb, tlast);
      end
      ready_en_m = 1;
    end
  end

  // Hold all inputs for one clock
  task automatic applyStimulus(input bit v, input logic [TDW-1:0] d, input logic [LANES-1:0] s,
                               input bit l, input bit r, input bit f);
    tvalid    = v;
    tdata     = d;
    tstrb     = s;
    tlast     = l;
    vec_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  // Present one beat until the DUT accepts it, with a bounded wait
  task automatic sendBeat(input logic [TDW-1:0] d, input logic [LANES-1:0] s, input bit l);
    bit acc;
    acc    = 0;
    tvalid = 1'b1;
    tdata  = d;
    tstrb  = s;
    tlast  = l;
    flush  = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_timeout actual=not_accepted expected=accepted at %0t", $time);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // Directed probe on the next falling edge, then realign to just after the rising edge
  task automatic probe(input string name, input logic [63:0] act_sel, input logic [63:0] exp);
    @(negedge clk);
    case (act_sel)
      64'd0:   checkOutput(name, 64'(vec_valid), exp);
      64'd1:   checkOutput(name, 64'(fifo_level), exp);
      64'd2:   checkOutput(name, 64'(vec_data), exp);
      64'd3:   checkOutput(name, 64'(vec_last), exp);
      default: checkOutput(name, 64'(tready), exp);
    endcase
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e[MAC_NUM];
    logic [VEC_W-1:0] v18;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    tvalid    = 1'b0;
    tdata     = '0;
    tstrb     = '0;
    tlast     = 1'b0;
    vec_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, '0, '0, 0, 0, 0);

    // Two full beats form elements 1..8
    vec_ready = 1'b0;
    sendBeat(32'h04030201, 4'hF, 0);
    sendBeat(32'h08070605, 4'hF, 0);
    for (int i = 0; i < MAC_NUM; i++) e[i] = i + 1;
    v18 = packElems(e);
    @(negedge clk);
    checkOutput("dir_first_valid", 64'(vec_valid), 64'd1);
    checkOutput("dir_first_data", 64'(vec_data), 64'(v18));
    checkOutput("dir_first_last", 64'(vec_last), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, '0, '0, 0, 1, 0);

    // Strobed TLAST beat closes a padded vector
    vec_ready = 1'b0;
    sendBeat(32'h1F1F1F1F, 4'b0011, 1);
    probe("dir_tlast_data", 64'd2, 64'h3FF);
    probe("dir_tlast_last", 64'd3, 64'd1);
    applyStimulus(0, '0, '0, 0, 1, 0);

    // Back-pressure: fill FIFO, stall, then drain
    vec_ready = 1'b0;
    for (int b = 0; b < 4; b++) sendBeat(32'h01010101 * (b + 1), 4'hF, 0);
    applyStimulus(1, 32'h05050505, 4'hF, 0, 0, 0);
    applyStimulus(1, 32'h05050505, 4'hF, 0, 0, 0);
    tvalid = 1'b0;
    probe("dir_full_level", 64'd1, 64'd2);
    probe("dir_full_tready", 64'd4, 64'd0);
    vec_ready = 1'b1;
    sendBeat(32'h05050505, 4'hF, 0);
    sendBeat(32'h06060606, 4'hF, 0);
    repeat (4) applyStimulus(0, '0, '0, 0, 1, 0);

    // Full FIFO with a pop and a completing beat in the same cycle
    vec_ready = 1'b0;
    for (int b = 0; b < 4; b++) sendBeat(32'h11111111 + b, 4'hF, 0);
    tvalid    = 1'b1;
    tdata     = 32'h1A1B1C1D;
    tstrb     = 4'hF;
    tlast     = 1'b1;
    vec_ready = 1'b1;
    @(negedge clk);
    checkOutput("dir_pushpop_tready", 64'(tready), 64'd1);
    @(posedge clk);
    #1;
    tvalid    = 1'b0;
    tlast     = 1'b0;
    vec_ready = 1'b0;
    probe("dir_pushpop_level", 64'd1, 64'd2);
    repeat (4) applyStimulus(0, '0, '0, 0, 1, 0);

    // Flush mid-frame with one vector stored and a beat in the flush cycle
    vec_ready = 1'b0;
    sendBeat(32'h02020202, 4'hF, 0);
    sendBeat(32'h03030303, 4'hF, 0);
    sendBeat(32'h09090909, 4'hF, 0);
    applyStimulus(1, 32'h0A0A0A0A, 4'hF, 0, 0, 1);
    flush = 1'b0;
    probe("dir_flush_valid", 64'd0, 64'd0);
    probe("dir_flush_level", 64'd1, 64'd0);
    vec_ready = 1'b1;
    sendBeat(32'h04030201, 4'hF, 0);
    sendBeat(32'h08070605, 4'hF, 0);
    repeat (3) applyStimulus(0, '0, '0, 0, 1, 0);

    // Reset mid-frame, then realign to element 0
    sendBeat(32'h0F0F0F0F, 4'hF, 0);
    rst = 1'b1;
    applyStimulus(0, '0, '0, 0, 1, 0);
    rst = 1'b0;
    applyStimulus(0, '0, '0, 0, 0, 0);
    vec_ready = 1'b0;
    sendBeat(32'h04030201, 4'hF, 0);
    sendBeat(32'h08070605, 4'hF, 0);
    probe("dir_rst_realign", 64'd2, 64'(v18));
    repeat (3) applyStimulus(0, '0, '0, 0, 1, 0);

    // Randomised traffic with occasional flush
    for (int c = 0; c < 500; c++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, 4'($urandom), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end
    repeat (6) applyStimulus(0, '0, '0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
